// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - captures a ROW x COL window of a 1-bit VGA stream and checks frame geometry
module vga_frame_capture #(
  parameter int   ROW    = 30,
  parameter int   COL    = 30,
  parameter int   H_ACT  = 640,
  parameter int   V_ACT  = 480,
  parameter logic VS_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_DE,
  input  logic        i_pix,
  input  logic        arm,
  input  logic [11:0] rd_addr,
  output logic        rd_data,
  output logic        busy,
  output logic        frame_done,
  output logic        width_err,
  output logic        height_err,
  output logic        sync_err,
  output logic [11:0] line_cnt,
  output logic [15:0] ones_cnt
);

  localparam int DEPTH = ROW * COL;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t state_q, state_d;

  logic        vs_d_q, de_d_q;
  logic        vs_act, hs_act, frame_start, line_end;
  logic        cap_en, clr, done_hit, wr_en;
  logic [AW-1:0] wr_addr;

  logic [11:0] x_cnt_q, x_cnt_d;
  logic [11:0] y_cnt_q, y_cnt_d;
  logic [15:0] ones_q, ones_d;
  logic        werr_q, werr_d;
  logic        serr_q, serr_d;

  logic        frame_done_q, rd_data_q;
  logic        width_err_q, height_err_q, sync_err_q;
  logic [11:0] line_cnt_q;
  logic [15:0] ones_cnt_q;

  logic        bitmap_q [DEPTH];

  // HS shares the VS active level
  assign vs_act      = (VGA_VS == VS_POL);
  assign hs_act      = (VGA_HS == VS_POL);
  assign frame_start = vs_act & ~vs_d_q;
  assign line_end    = de_d_q & ~VGA_DE;

  assign wr_en   = cap_en & VGA_DE & (x_cnt_q < 12'(COL)) & (y_cnt_q < 12'(ROW));
  assign wr_addr = AW'(y_cnt_q) * AW'(COL) + AW'(x_cnt_q);

  // Delayed copies of VS and DE for edge detection
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      vs_d_q <= 1'b0;
      de_d_q <= 1'b0;
    end else begin
      vs_d_q <= vs_act;
      de_d_q <= VGA_DE;
    end
  end

  // FSM state register
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; arm is ignored while a capture is pending or running
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm)         state_d = WAIT_VS;
      WAIT_VS: if (frame_start) state_d = CAPTURE;
      CAPTURE: if (frame_start) state_d = DONE;
      DONE:    if (arm)         state_d = WAIT_VS;
      default:                  state_d = IDLE;
    endcase
  end

  // FSM outputs: busy, counter clear, capture enable, end-of-frame hit
  always_comb begin
    busy     = 1'b0;
    clr      = 1'b0;
    cap_en   = 1'b0;
    done_hit = 1'b0;
    case (state_q)
      WAIT_VS: begin
        busy = 1'b1;
        clr  = 1'b1;
      end
      CAPTURE: begin
        busy     = 1'b1;
        cap_en   = 1'b1;
        done_hit = frame_start;
      end
      default: ;
    endcase
  end

  // Per-frame coordinate, ones and sticky error tracking
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    ones_d  = ones_q;
    werr_d  = werr_q;
    serr_d  = serr_q;
    if (clr) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
      ones_d  = '0;
      werr_d  = 1'b0;
      serr_d  = 1'b0;
    end else if (cap_en) begin
      if (line_end) begin
        x_cnt_d = '0;
        if (y_cnt_q != 12'hFFF) y_cnt_d = y_cnt_q + 12'd1;
        if (x_cnt_q != 12'(H_ACT)) werr_d = 1'b1;
      end else if (VGA_DE && x_cnt_q != 12'hFFF) begin
        x_cnt_d = x_cnt_q + 12'd1;
      end
      if (wr_en && i_pix && ones_q != 16'hFFFF) ones_d = ones_q + 16'd1;
      if (VGA_DE && (hs_act || vs_act)) serr_d = 1'b1;
      // a new frame arriving mid-line means the last line was truncated
      if (frame_start && (VGA_DE || de_d_q)) werr_d = 1'b1;
    end
  end

  // Working counters and result latches; results move only on frame end
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      ones_q       <= '0;
      werr_q       <= 1'b0;
      serr_q       <= 1'b0;
      frame_done_q <= 1'b0;
      line_cnt_q   <= '0;
      ones_cnt_q   <= '0;
      width_err_q  <= 1'b0;
      height_err_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      ones_q       <= ones_d;
      werr_q       <= werr_d;
      serr_q       <= serr_d;
      frame_done_q <= done_hit;
      if (done_hit) begin
        line_cnt_q   <= y_cnt_d;
        ones_cnt_q   <= ones_d;
        width_err_q  <= werr_d;
        height_err_q <= (y_cnt_d != 12'(V_ACT));
        sync_err_q   <= serr_d;
      end
    end
  end

  // Bitmap storage, deliberately not reset
  always_ff @(posedge vga_clk) begin
    if (wr_en) bitmap_q[wr_addr] <= i_pix;
  end

  // Registered readback; addresses past the window read as 0
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst)                       rd_data_q <= 1'b0;
    else if (rd_addr < 12'(DEPTH)) rd_data_q <= bitmap_q[rd_addr[AW-1:0]];
    else                           rd_data_q <= 1'b0;
  end

  assign rd_data    = rd_data_q;
  assign frame_done = frame_done_q;
  assign width_err  = width_err_q;
  assign height_err = height_err_q;
  assign sync_err   = sync_err_q;
  assign line_cnt   = line_cnt_q;
  assign ones_cnt   = ones_cnt_q;

endmodule
